// File: rtl/spram_sort_ctrl.sv
// Frame sorter controller: loads N samples into an external single-port RAM,
// bubble-sorts them in place (ascending, unsigned) and reports the median element.
module spram_sort_ctrl #(
   parameter int N = 540,
   parameter int W = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] din,
   input  logic         din_valid,
   output logic         din_ready,
   output logic [W-1:0] ram_data,
   output logic [9:0]   ram_addr,
   output logic         ram_we,
   input  logic [W-1:0] ram_q,
   output logic         busy,
   output logic [W-1:0] median,
   output logic         done
);

   typedef enum logic [3:0] {
      IDLE, LOAD, RD0, RD1, CAP, CMP, WR0, WR1, MRD0, MRD1, DONE
   } state_t;

   localparam logic [9:0] LAST_IDX  = 10'(N - 1);
   localparam logic [9:0] PASS_INIT = 10'(N - 2);
   localparam logic [9:0] MID_IDX   = 10'(N / 2);

   state_t       state_q, state_d;
   logic [9:0]   cnt_q, cnt_d;
   logic [9:0]   i_q, i_d;
   logic [9:0]   lim_q, lim_d;
   logic [9:0]   addr_q, addr_d;
   logic         swap_q, swap_d;
   logic [W-1:0] a_q, a_d;
   logic [W-1:0] b_q, b_d;
   logic [W-1:0] median_q, median_d;
   logic         done_q, done_d;
   logic         we_d;
   logic [W-1:0] wdata_d;
   logic         accept;
   logic         advance;
   logic         loading;

   assign loading = (state_q == IDLE) || (state_q == LOAD);
   assign accept  = din_valid && din_ready;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      i_d      = i_q;
      lim_d    = lim_q;
      swap_d   = swap_q;
      addr_d   = addr_q;
      a_d      = a_q;
      b_d      = b_q;
      median_d = median_q;
      done_d   = 1'b0;
      we_d     = 1'b0;
      wdata_d  = '0;
      advance  = 1'b0;

      case (state_q)
         IDLE, LOAD: begin
            if (accept) begin
               we_d    = 1'b1;
               addr_d  = cnt_q;
               wdata_d = din;
               if (cnt_q == LAST_IDX) begin
                  state_d = RD0;
                  cnt_d   = '0;
                  i_d     = '0;
                  lim_d   = PASS_INIT;
                  swap_d  = 1'b0;
               end else begin
                  state_d = LOAD;
                  cnt_d   = cnt_q + 10'd1;
               end
            end
         end
         RD0: begin
            addr_d  = i_q;
            state_d = RD1;
         end
         // RAM returns data one cycle after the address, so A arrives in RD1, B in CAP
         RD1: begin
            addr_d  = i_q + 10'd1;
            a_d     = ram_q;
            state_d = CAP;
         end
         CAP: begin
            b_d     = ram_q;
            state_d = CMP;
         end
         CMP: begin
            if (a_q > b_q) state_d = WR0;
            else           advance = 1'b1;
         end
         WR0: begin
            we_d    = 1'b1;
            addr_d  = i_q;
            wdata_d = b_q;
            state_d = WR1;
         end
         WR1: begin
            we_d    = 1'b1;
            addr_d  = i_q + 10'd1;
            wdata_d = a_q;
            swap_d  = 1'b1;
            advance = 1'b1;
         end
         MRD0: begin
            addr_d  = MID_IDX;
            state_d = MRD1;
         end
         MRD1: state_d = DONE;
         DONE: begin
            median_d = ram_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // swap_d already reflects a swap written in WR1 this cycle
      if (advance) begin
         if (i_q < lim_q) begin
            i_d     = i_q + 10'd1;
            state_d = RD0;
         end else if (!swap_d || (lim_q == '0)) begin
            state_d = MRD0;
         end else begin
            lim_d   = lim_q - 10'd1;
            i_d     = '0;
            swap_d  = 1'b0;
            state_d = RD0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         i_q      <= '0;
         lim_q    <= '0;
         swap_q   <= 1'b0;
         addr_q   <= '0;
         median_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         i_q      <= i_d;
         lim_q    <= lim_d;
         swap_q   <= swap_d;
         addr_q   <= addr_d;
         median_q <= median_d;
         done_q   <= done_d;
      end
   end

   always_ff @(posedge clk) begin
      a_q <= a_d;
      b_q <= b_d;
   end

   // Outputs are forced quiet while reset is held, independent of the stored state
   assign din_ready = !rst && loading;
   assign busy      = !rst && !loading;
   assign ram_we    = !rst && we_d;
   assign ram_addr  = rst ? '0 : addr_d;
   assign ram_data  = rst ? '0 : wdata_d;
   assign median    = rst ? '0 : median_q;
   assign done      = !rst && done_q;

endmodule

// File: tb/tb_spram_sort_ctrl.sv
// Bench for spram_sort_ctrl: an N=8 instance for the directed frames and a
// default N=540 instance for a large random frame, each with its own RAM model.
module tb_spram_sort_ctrl;
   localparam int W  = 24;
   localparam int NS = 8;
   localparam int NB = 540;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;
   int   cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int           n_chk = 0;
   int           n_fail = 0;
   logic [W-1:0] exp_q[$];

   int           acc_cyc, lat, busy_we, busy_rdy, stray_we, ld_we, ld_done;
   bit           got_done;
   logic         done_next;
   logic [W-1:0] med_obs;

   // N=8 instance and its RAM
   logic [W-1:0] din_s, wd_s, q_s, med_s;
   logic         vld_s, rdy_s, we_s, busy_s, done_s;
   logic [9:0]   ad_s, ar_s;
   logic [W-1:0] mem_s [1024];

   spram_sort_ctrl #(.N(NS), .W(W)) u_small (
      .clk(clk), .rst(rst), .din(din_s), .din_valid(vld_s), .din_ready(rdy_s),
      .ram_data(wd_s), .ram_addr(ad_s), .ram_we(we_s), .ram_q(q_s),
      .busy(busy_s), .median(med_s), .done(done_s)
   );

   always @(posedge clk) begin
      if (we_s) mem_s[ad_s] <= wd_s;
      ar_s <= ad_s;
   end
   assign q_s = mem_s[ar_s];

   // N=540 instance and its RAM
   logic [W-1:0] din_b, wd_b, q_b, med_b;
   logic         vld_b, rdy_b, we_b, busy_b, done_b;
   logic [9:0]   ad_b, ar_b;
   logic [W-1:0] mem_b [1024];

   spram_sort_ctrl u_big (
      .clk(clk), .rst(rst), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
      .ram_data(wd_b), .ram_addr(ad_b), .ram_we(we_b), .ram_q(q_b),
      .busy(busy_b), .median(med_b), .done(done_b)
   );

   always @(posedge clk) begin
      if (we_b) mem_b[ad_b] <= wd_b;
      ar_b <= ad_b;
   end
   assign q_b = mem_b[ar_b];

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached, n_fail=%0d", n_fail);
      $fatal(1);
   end

   // Feeds one frame into the N=8 instance; returns one cycle after the last accept.
   task automatic load_s(input logic [W-1:0] d [NS], input bit rnd, input bit hold);
      int k = 0;
      ld_we = 0;
      ld_done = 0;
      for (int g = 0; g < 2000 && k < NS; g++) begin
         vld_s = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         din_s = vld_s ? d[k] : W'($urandom);
         @(negedge clk);
         if (we_s) ld_we++;
         if (done_s) ld_done++;
         if (vld_s && rdy_s) begin
            k++;
            acc_cyc = cyc;
         end
         @(posedge clk); #1;
      end
      if (hold) din_s = 24'hABCDEF;
      else      vld_s = 1'b0;
   endtask

   // Observes the N=8 instance until done, gathering counters for the caller.
   task automatic wait_s(input int budget);
      got_done  = 0;
      busy_we   = 0;
      busy_rdy  = 0;
      stray_we  = 0;
      done_next = 1'b1;
      for (int c = 0; c < budget && !got_done; c++) begin
         @(negedge clk);
         if (done_s) begin
            got_done = 1;
            lat      = cyc - acc_cyc;
            med_obs  = med_s;
            vld_s    = 1'b0;
         end else begin
            if (we_s && busy_s)  busy_we++;
            if (we_s && !busy_s) stray_we++;
            if (rdy_s && busy_s) busy_rdy++;
         end
      end
      if (got_done) begin
         @(negedge clk);
         done_next = done_s;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      vld_s = 1'b1;
      din_s = 24'h123456;
      vld_b = 1'b0;
      din_b = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if ({rdy_s, busy_s, done_s, we_s, ad_s, wd_s, med_s} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h required 0",
                  {rdy_s, busy_s, done_s, we_s, ad_s, wd_s, med_s});
      end
      vld_s = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if (rdy_s !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready_after: got %b required 1", rdy_s);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reverse();
      logic [W-1:0] d [NS];
      logic [W-1:0] e;
      for (int k = 0; k < NS; k++) d[k] = W'(NS - 1 - k);
      exp_q.push_back(24'd4);
      load_s(d, 1'b0, 1'b0);
      wait_s(1000);
      e = exp_q.pop_front();
      n_chk++;
      if (!got_done) begin n_fail++; $display("FAIL reverse_done: got none required pulse"); end
      n_chk++;
      if (med_obs !== e) begin n_fail++; $display("FAIL reverse_median: got %0d required %0d", med_obs, e); end
      n_chk++;
      if (lat != 172) begin n_fail++; $display("FAIL reverse_latency: got %0d required 172", lat); end
      n_chk++;
      if (done_next !== 1'b0) begin n_fail++; $display("FAIL reverse_done_width: got %b required 0", done_next); end
      for (int k = 0; k < NS; k++) begin
         n_chk++;
         if (mem_s[k] !== W'(k)) begin
            n_fail++;
            $display("FAIL reverse_ram[%0d]: got %0d required %0d", k, mem_s[k], k);
         end
      end
   endtask

   task automatic test_presorted();
      logic [W-1:0] d [NS];
      logic [W-1:0] e;
      for (int k = 0; k < NS; k++) d[k] = W'(k);
      exp_q.push_back(24'd4);
      load_s(d, 1'b0, 1'b0);
      wait_s(1000);
      e = exp_q.pop_front();
      n_chk++;
      if (!got_done || med_obs !== e) begin n_fail++; $display("FAIL presorted_median: got %0d required %0d", med_obs, e); end
      n_chk++;
      if (lat != 32) begin n_fail++; $display("FAIL presorted_latency: got %0d required 32", lat); end
      n_chk++;
      if (busy_we != 0) begin n_fail++; $display("FAIL presorted_writes: got %0d required 0", busy_we); end
      n_chk++;
      if (done_next !== 1'b0) begin n_fail++; $display("FAIL presorted_done_width: got %b required 0", done_next); end
   endtask

   task automatic test_equal();
      logic [W-1:0] d [NS];
      logic [W-1:0] e;
      for (int k = 0; k < NS; k++) d[k] = (k == 3) ? 24'd1 : 24'd5;
      exp_q.push_back(24'd5);
      load_s(d, 1'b0, 1'b0);
      wait_s(1000);
      e = exp_q.pop_front();
      n_chk++;
      if (!got_done || med_obs !== e) begin n_fail++; $display("FAIL equal_median: got %0d required %0d", med_obs, e); end
      n_chk++;
      if (busy_we != 6) begin n_fail++; $display("FAIL equal_swap_writes: got %0d required 6", busy_we); end
      n_chk++;
      if (lat != 98) begin n_fail++; $display("FAIL equal_latency: got %0d required 98", lat); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] d [NS];
      logic [W-1:0] s[$];
      logic [W-1:0] e;
      for (int k = 0; k < NS; k++) begin
         d[k] = W'($urandom);
         s.push_back(d[k]);
      end
      s.sort();
      exp_q.push_back(s[NS/2]);
      load_s(d, 1'b1, 1'b1);
      wait_s(1000);
      e = exp_q.pop_front();
      n_chk++;
      if (!got_done || med_obs !== e) begin n_fail++; $display("FAIL b2b_median: got %h required %h", med_obs, e); end
      n_chk++;
      if (ld_we != NS) begin n_fail++; $display("FAIL b2b_load_writes: got %0d required %0d", ld_we, NS); end
      n_chk++;
      if (busy_rdy != 0) begin n_fail++; $display("FAIL b2b_ready_busy: got %0d required 0", busy_rdy); end
      n_chk++;
      if (stray_we != 0) begin n_fail++; $display("FAIL b2b_stray_writes: got %0d required 0", stray_we); end
      for (int k = 0; k < NS; k++) begin
         n_chk++;
         if (mem_s[k] !== s[k]) begin
            n_fail++;
            $display("FAIL b2b_ram[%0d]: got %h required %h", k, mem_s[k], s[k]);
         end
      end
   endtask

   task automatic test_reset_midsort();
      logic [W-1:0] d [NS];
      logic [W-1:0] n [NS];
      logic [W-1:0] e;
      for (int k = 0; k < NS; k++) d[k] = W'(NS - 1 - k);
      n = '{24'd9, 24'd1, 24'd8, 24'd2, 24'd7, 24'd3, 24'd6, 24'd4};
      load_s(d, 1'b0, 1'b0);
      repeat (40) @(posedge clk);
      @(negedge clk);
      n_chk++;
      if (busy_s !== 1'b1) begin n_fail++; $display("FAIL midsort_busy: got %b required 1", busy_s); end
      @(posedge clk); #1;
      rst   = 1'b1;
      vld_s = 1'b1;
      din_s = 24'h55AA55;
      @(negedge clk);
      n_chk++;
      if ({rdy_s, busy_s, done_s, we_s, ad_s, wd_s, med_s} !== '0) begin
         n_fail++;
         $display("FAIL midsort_reset_outputs: got %h required 0",
                  {rdy_s, busy_s, done_s, we_s, ad_s, wd_s, med_s});
      end
      @(posedge clk); #1;
      vld_s = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_chk++;
      if ({rdy_s, busy_s, done_s} !== 3'b100) begin
         n_fail++;
         $display("FAIL midsort_after_reset: got %b required 100", {rdy_s, busy_s, done_s});
      end
      @(posedge clk); #1;
      exp_q.push_back(24'd6);
      load_s(n, 1'b0, 1'b0);
      wait_s(1000);
      e = exp_q.pop_front();
      n_chk++;
      if (ld_done != 0) begin n_fail++; $display("FAIL midsort_stale_done: got %0d required 0", ld_done); end
      n_chk++;
      if (!got_done || med_obs !== e) begin n_fail++; $display("FAIL midsort_median: got %0d required %0d", med_obs, e); end
      n_chk++;
      if (lat <= 32 || lat > 172) begin n_fail++; $display("FAIL midsort_latency: got %0d required 33..172", lat); end
   endtask

   task automatic test_big();
      logic [W-1:0] r[$];
      logic [W-1:0] s[$];
      logic [W-1:0] v;
      logic [W-1:0] e;
      int           idx;
      int           k;
      int           bad;
      bit           seen;
      for (int j = 0; j < NB; j++) r.push_back(W'($urandom));
      r[3]   = 24'hFFFFFF;
      r[100] = 24'hFFFFFF;
      r[200] = 24'h800000;
      r[300] = 24'h000000;
      r.sort();
      exp_q.push_back(r[NB/2]);
      // Mostly ordered frame with a few elements pulled to the front keeps run time short
      s = r;
      v = s.pop_back();
      s.push_front(v);
      for (int j = 0; j < 5; j++) begin
         idx = $urandom_range(10, NB - 1);
         v = s[idx];
         s.delete(idx);
         s.push_front(v);
      end
      k = 0;
      for (int g = 0; g < 5000 && k < NB; g++) begin
         vld_b = 1'b1;
         din_b = s[k];
         @(negedge clk);
         if (vld_b && rdy_b) k++;
         @(posedge clk); #1;
      end
      vld_b = 1'b0;
      seen = 0;
      for (int c = 0; c < 60000 && !seen; c++) begin
         @(negedge clk);
         if (done_b) begin
            seen = 1;
            med_obs = med_b;
         end
      end
      e = exp_q.pop_front();
      n_chk++;
      if (!seen) begin n_fail++; $display("FAIL big_done: got none required pulse"); end
      n_chk++;
      if (med_obs !== e) begin n_fail++; $display("FAIL big_median: got %h required %h", med_obs, e); end
      bad = 0;
      for (int j = 0; j < NB; j++) if (mem_b[j] !== r[j]) bad++;
      n_chk++;
      if (bad != 0) begin n_fail++; $display("FAIL big_ram_order: got %0d misplaced required 0", bad); end
      @(posedge clk); #1;
   endtask

   initial begin
      rst   = 1'b1;
      vld_s = 1'b0;
      din_s = '0;
      vld_b = 1'b0;
      din_b = '0;
      test_reset();
      test_reverse();
      test_presorted();
      test_equal();
      test_back_to_back();
      test_reset_midsort();
      test_big();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
